// File: rtl/approx_mul_err_sweeper.sv
// Sweeps every operand pair through an external approximate multiplier and
// accumulates correct/wrong counts plus total and maximum error distance.
module approx_mul_err_sweeper #(
    parameter int W     = 8,
    parameter int START = 1,
    parameter int ERR_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic [2*W-1:0]   approx_p,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     num_correct,
    output logic [2*W:0]     num_wrong,
    output logic [ERR_W-1:0] err_sum,
    output logic [2*W-1:0]   err_max
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [W-1:0] START_V = W'(START);
    localparam logic [W-1:0] MAX_V   = {W{1'b1}};

    state_t             state_q, state_d;
    logic [W-1:0]       op_a_q, op_a_d, op_b_q, op_b_d;
    logic               v1_q, v1_d;
    logic [2*W-1:0]     dist_q, dist_d;
    logic               done_q, done_d;
    logic [2*W:0]       num_correct_q, num_correct_d, num_wrong_q, num_wrong_d;
    logic [ERR_W-1:0]   err_sum_q, err_sum_d;
    logic [2*W-1:0]     err_max_q, err_max_d;

    logic               accept;
    logic               last_pair;
    logic [2*W-1:0]     exact;
    logic [ERR_W:0]     sum_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_a_q        <= '0;
            op_b_q        <= '0;
            v1_q          <= 1'b0;
            dist_q        <= '0;
            done_q        <= 1'b0;
            num_correct_q <= '0;
            num_wrong_q   <= '0;
            err_sum_q     <= '0;
            err_max_q     <= '0;
        end else begin
            state_q       <= state_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            v1_q          <= v1_d;
            dist_q        <= dist_d;
            done_q        <= done_d;
            num_correct_q <= num_correct_d;
            num_wrong_q   <= num_wrong_d;
            err_sum_q     <= err_sum_d;
            err_max_q     <= err_max_d;
        end
    end

    assign accept    = (state_q == IDLE) && start && !abort;
    assign last_pair = (op_a_q == MAX_V) && (op_b_q == MAX_V);

    // DRAIN lasts one cycle: the last pair's stage-1 result is consumed on its way out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (abort) state_d = IDLE;
                     else if (last_pair) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        num_correct_d = num_correct_q;
        num_wrong_d   = num_wrong_q;
        err_sum_d     = err_sum_q;
        err_max_d     = err_max_q;

        exact   = {{W{1'b0}}, op_a_q} * {{W{1'b0}}, op_b_q};
        dist_d  = (approx_p >= exact) ? (approx_p - exact) : (exact - approx_p);
        v1_d    = (state_q == RUN) && !abort;
        done_d  = (state_q == DRAIN) && !abort;
        sum_ext = {1'b0, err_sum_q} + (ERR_W+1)'(dist_q);

        if (state_q == RUN && !abort && !last_pair) begin
            if (op_b_q != MAX_V) begin
                op_b_d = op_b_q + 1'b1;
            end else begin
                op_b_d = START_V;
                op_a_d = op_a_q + 1'b1;
            end
        end

        // An abort discards the pair still sitting in stage 1.
        if (v1_q && !abort) begin
            if (dist_q == '0) num_correct_d = num_correct_q + 1'b1;
            else              num_wrong_d   = num_wrong_q + 1'b1;
            err_sum_d = sum_ext[ERR_W] ? {ERR_W{1'b1}} : sum_ext[ERR_W-1:0];
            if (dist_q > err_max_q) err_max_d = dist_q;
        end

        if (accept) begin
            op_a_d        = START_V;
            op_b_d        = START_V;
            num_correct_d = '0;
            num_wrong_d   = '0;
            err_sum_d     = '0;
            err_max_d     = '0;
        end
    end

    always_comb begin
        busy        = (state_q == RUN) || (state_q == DRAIN);
        done        = done_q;
        op_a        = op_a_q;
        op_b        = op_b_q;
        num_correct = num_correct_q;
        num_wrong   = num_wrong_q;
        err_sum     = err_sum_q;
        err_max     = err_max_q;
    end

endmodule

// File: tb/tb_approx_mul_err_sweeper.sv
// Directed bench: a W=3 instance with selectable multiplier stubs and a
// full-size W=8 instance with an exact multiplier.
module tb_approx_mul_err_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        start3, abort3, busy3, done3;
    logic [2:0]  op_a3, op_b3;
    logic [5:0]  approx_p3, exact3;
    logic [6:0]  num_correct3, num_wrong3;
    logic [31:0] err_sum3;
    logic [5:0]  err_max3;

    logic        start8, abort8, busy8, done8;
    logic [7:0]  op_a8, op_b8;
    logic [15:0] approx_p8;
    logic [16:0] num_correct8, num_wrong8;
    logic [31:0] err_sum8;
    logic [15:0] err_max8;

    int stubMode;
    int checks = 0;
    int errors = 0;

    approx_mul_err_sweeper #(.W(3), .START(1), .ERR_W(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .op_a(op_a3), .op_b(op_b3), .approx_p(approx_p3),
        .busy(busy3), .done(done3),
        .num_correct(num_correct3), .num_wrong(num_wrong3),
        .err_sum(err_sum3), .err_max(err_max3)
    );

    approx_mul_err_sweeper #(.W(8), .START(1), .ERR_W(32)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
        .op_a(op_a8), .op_b(op_b8), .approx_p(approx_p8),
        .busy(busy8), .done(done8),
        .num_correct(num_correct8), .num_wrong(num_wrong8),
        .err_sum(err_sum8), .err_max(err_max8)
    );

    // Multiplier stubs standing in for the approximate designs under test.
    always_comb begin
        exact3    = 6'(op_a3) * 6'(op_b3);
        approx_p3 = exact3;
        case (stubMode)
            1: approx_p3 = exact3 ^ 6'd1;
            2: approx_p3 = 6'd0;
            3: begin
                if (op_a3 == 3'd5 && op_b3 == 3'd6) approx_p3 = exact3 - 6'd3;
                if (op_a3 == 3'd7 && op_b3 == 3'd7) approx_p3 = exact3 + 6'd2;
            end
            default: approx_p3 = exact3;
        endcase
        approx_p8 = 16'(op_a8) * 16'(op_b8);
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit sel8, input logic s, input logic a);
        if (sel8) begin
            start8 = s;
            abort8 = a;
        end else begin
            start3 = s;
            abort3 = a;
        end
    endtask

    // Starts a sweep at the next edge and returns in the done cycle (or at the bound).
    task automatic runSweep(input bit sel8, input int expCycles);
        int c;
        applyStimulus(sel8, 1'b1, 1'b0);
        tick();
        applyStimulus(sel8, 1'b0, 1'b0);
        c = 1;
        checkOutput("first busy", sel8 ? busy8 : busy3, 1);
        checkOutput("first done low", sel8 ? done8 : done3, 0);
        checkOutput("first op_a", sel8 ? 8'(op_a8) : 8'(op_a3), 1);
        checkOutput("first op_b", sel8 ? 8'(op_b8) : 8'(op_b3), 1);
        while (!(sel8 ? done8 : done3) && c < expCycles + 10) begin
            tick();
            c++;
        end
        checkOutput("done latency", c, expCycles);
        checkOutput("busy in done cycle", sel8 ? busy8 : busy3, 0);
    endtask

    initial begin
        bit sawDone;
        stubMode = 0;
        rst_n    = 1'b0;
        start3 = 1'b0; abort3 = 1'b0;
        start8 = 1'b0; abort8 = 1'b0;
        tick();
        tick();
        checkOutput("reset op_a3", op_a3, 0);
        checkOutput("reset op_b3", op_b3, 0);
        checkOutput("reset busy3", busy3, 0);
        checkOutput("reset done3", done3, 0);
        checkOutput("reset correct3", num_correct3, 0);
        checkOutput("reset busy8", busy8, 0);
        checkOutput("reset err_sum8", err_sum8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] W=3 stub exact XOR 1");
        stubMode = 1;
        runSweep(0, 51);
        checkOutput("xor correct", num_correct3, 0);
        checkOutput("xor wrong", num_wrong3, 49);
        checkOutput("xor err_sum", err_sum3, 49);
        checkOutput("xor err_max", err_max3, 1);

        $display("[TB] W=3 stub zero, started in the done cycle");
        stubMode = 2;
        runSweep(0, 51);
        checkOutput("zero correct", num_correct3, 0);
        checkOutput("zero wrong", num_wrong3, 49);
        checkOutput("zero err_sum", err_sum3, 784);
        checkOutput("zero err_max", err_max3, 49);

        $display("[TB] W=3 stub with negative and positive errors");
        stubMode = 3;
        runSweep(0, 51);
        checkOutput("signed correct", num_correct3, 47);
        checkOutput("signed wrong", num_wrong3, 2);
        checkOutput("signed err_sum", err_sum3, 5);
        checkOutput("signed err_max", err_max3, 3);
        tick();
        checkOutput("done one cycle", done3, 0);
        tick();
        checkOutput("results held idle", err_sum3, 5);

        $display("[TB] W=3 abort mid-sweep");
        stubMode = 0;
        applyStimulus(0, 1'b1, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 1'b0);
        tick();
        checkOutput("cycle2 correct", num_correct3, 0);
        tick();
        checkOutput("cycle3 correct", num_correct3, 1);
        repeat (5) tick();
        checkOutput("cycle8 op_a", op_a3, 2);
        checkOutput("cycle8 op_b", op_b3, 1);
        tick();
        tick();
        applyStimulus(0, 1'b1, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("restart ignored busy", busy3, 1);
        checkOutput("cycle11 op_a", op_a3, 2);
        checkOutput("cycle11 op_b", op_b3, 4);
        repeat (9) tick();
        checkOutput("cycle20 correct", num_correct3, 18);
        applyStimulus(0, 1'b0, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("abort busy", busy3, 0);
        checkOutput("abort done", done3, 0);
        checkOutput("abort count", 8'(num_correct3) + 8'(num_wrong3), 18);
        sawDone = 1'b0;
        repeat (5) begin
            tick();
            if (done3) sawDone = 1'b1;
        end
        checkOutput("no done after abort", sawDone, 0);
        checkOutput("abort held correct", num_correct3, 18);
        applyStimulus(0, 1'b1, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 1'b0);
        tick();
        checkOutput("start+abort busy", busy3, 0);
        checkOutput("start+abort correct", num_correct3, 18);
        checkOutput("start+abort wrong", num_wrong3, 0);

        $display("[TB] W=8 reset mid-sweep");
        applyStimulus(1, 1'b1, 1'b0);
        tick();
        applyStimulus(1, 1'b0, 1'b0);
        repeat (999) tick();
        checkOutput("cycle1000 op_a", op_a8, 4);
        checkOutput("cycle1000 op_b", op_b8, 235);
        checkOutput("cycle1000 correct", num_correct8, 998);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async op_a", op_a8, 0);
        checkOutput("async op_b", op_b8, 0);
        checkOutput("async busy", busy8, 0);
        checkOutput("async done", done8, 0);
        checkOutput("async correct", num_correct8, 0);
        checkOutput("async wrong", num_wrong8, 0);
        checkOutput("async err_sum", err_sum8, 0);
        checkOutput("async err_max", err_max8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] W=8 full exact sweep");
        runSweep(1, 65027);
        checkOutput("full correct", num_correct8, 65025);
        checkOutput("full wrong", num_wrong8, 0);
        checkOutput("full err_sum", err_sum8, 0);
        checkOutput("full err_max", err_max8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
